// File: rtl/flex_enable_divider.sv
// flex_enable_divider: multi-channel programmable divider for single-cycle
// enable strobes. Each channel emits one registered slow_enable pulse per R
// counted fast_enable strobes. R is sampled from ratio into a shadow register
// when the channel is idle, when it wraps, and when it is cleared.
// Optional build macro FLEX_DIV_FIRST_EN: the first counted strobe after
// reset, clear or leaving IDLE is treated as terminal (leading-edge aligned
// output). When it is undefined the first pulse comes after R strobes.
module flex_enable_divider #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             fast_enable,
  input  logic [NUM_CH-1:0]             clear,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   ratio,
  output logic [NUM_CH-1:0]             slow_enable,
  output logic [NUM_CH-1:0]             active
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q [NUM_CH];
  state_t               state_d [NUM_CH];
  logic [CNT_WIDTH-1:0] s_q     [NUM_CH];
  logic [CNT_WIDTH-1:0] s_d     [NUM_CH];
  logic [CNT_WIDTH-1:0] c_q     [NUM_CH];
  logic [CNT_WIDTH-1:0] c_d     [NUM_CH];
  logic [CNT_WIDTH-1:0] ratio_ch[NUM_CH];
  logic [NUM_CH-1:0]    slow_q;
  logic [NUM_CH-1:0]    slow_d;
  logic [NUM_CH-1:0]    terminal;
`ifdef FLEX_DIV_FIRST_EN
  logic [NUM_CH-1:0]    first_q;
  logic [NUM_CH-1:0]    first_d;
`endif

  // Unpack the ratio bus and flag strobes that close a division period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ratio_ch[i] = ratio[i*CNT_WIDTH +: CNT_WIDTH];
`ifdef FLEX_DIV_FIRST_EN
      terminal[i] = (c_q[i] == (s_q[i] - CNT_ONE)) || first_q[i];
`else
      terminal[i] = (c_q[i] == (s_q[i] - CNT_ONE));
`endif
    end
  end

  // Per-channel next-state: clear dominates, IDLE tracks ratio, COUNT counts.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      s_d[i]     = s_q[i];
      c_d[i]     = c_q[i];
      slow_d[i]  = 1'b0;
`ifdef FLEX_DIV_FIRST_EN
      first_d[i] = first_q[i];
`endif
      if (clear[i] || (state_q[i] == IDLE)) begin
        // Realign: any strobe in this cycle is dropped, ratio is resampled.
        c_d[i]     = '0;
        s_d[i]     = ratio_ch[i];
        state_d[i] = (ratio_ch[i] != '0) ? COUNT : IDLE;
`ifdef FLEX_DIV_FIRST_EN
        first_d[i] = 1'b1;
`endif
      end else if (fast_enable[i]) begin
        if (terminal[i]) begin
          // Wrap: pulse next cycle and pick up any new ratio only here.
          slow_d[i]  = 1'b1;
          c_d[i]     = '0;
          s_d[i]     = ratio_ch[i];
          state_d[i] = (ratio_ch[i] != '0) ? COUNT : IDLE;
`ifdef FLEX_DIV_FIRST_EN
          first_d[i] = 1'b0;
`endif
        end else begin
          c_d[i] = c_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Channel registers; reset forces outputs low without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        s_q[i]     <= '0;
        c_q[i]     <= '0;
      end
      slow_q  <= '0;
`ifdef FLEX_DIV_FIRST_EN
      first_q <= '1;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        s_q[i]     <= s_d[i];
        c_q[i]     <= c_d[i];
      end
      slow_q  <= slow_d;
`ifdef FLEX_DIV_FIRST_EN
      first_q <= first_d;
`endif
    end
  end

  // Outputs: registered pulse, activity decoded straight from the state flop.
  always_comb begin
    slow_enable = slow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state_q[i] == COUNT);
    end
  end

endmodule
